usrt_rx_fifo: RTL
=================

USRT_RX_FIFO -- requirements
Module: usrt_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of byte entries; a power of two, 2..64.
REQ-002 SHALL have parameter CW, default 4: count width, equal to log2(DEPTH)+1.
REQ-003 SHALL have port pClk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port pReset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port uRst, input, 1: synchronous flush from the transfer coordinator, active-high.
REQ-006 SHALL have port wr_valid, input, 1: deserializer presents a complete, checked byte; one-cycle pulse.
REQ-007 SHALL have port wr_data, input, 8: deserialized byte, qualified by wr_valid.
REQ-008 SHALL have port rd_en, input, 1: AMBA-side read strobe (pop request).
REQ-009 SHALL have port rd_data, output, 8: popped byte, registered.
REQ-010 SHALL have port rd_valid, output, 1: rd_data holds a newly popped byte; one-cycle pulse.
REQ-011 SHALL have port empty, output, 1: no stored entries.
REQ-012 SHALL have port full, output, 1: DEPTH stored entries.
REQ-013 SHALL have port count, output, CW: number of stored entries, 0..DEPTH.
REQ-014 SHALL have port overrun, output, 1: sticky flag, a byte was dropped because the FIFO was full.
REQ-015 SHALL have port ovr_clr, input, 1: clears overrun.

Function
REQ-016 SHALL accept a push when wr_valid=1 and (full=0 or an accepted pop occurs in the same cycle), storing wr_data at the write pointer.
REQ-017 SHALL accept a pop when rd_en=1 and empty=0; rd_en while empty SHALL be ignored, leaving rd_valid=0 and rd_data unchanged.
REQ-018 SHALL present the popped byte on rd_data with rd_valid=1 exactly one cycle after the accepted rd_en; there is no fall-through of a same-cycle push into an empty FIFO.
REQ-019 SHALL give both pointers log2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-020 SHALL update count by +1 for a push only, -1 for a pop only, and 0 for both or neither; empty and full SHALL be derived from count.
REQ-021 SHALL, when full with wr_valid=1 and no accepted pop, drop the incoming byte, leave storage and pointers unchanged, and set overrun the next cycle.
REQ-022 SHALL, on simultaneous ovr_clr and a new overflow event, leave overrun at 1 (set wins).
REQ-023 SHALL, on uRst=1, zero the pointers and count, force rd_valid to 0 and ignore push and pop in that cycle; rd_data and overrun SHALL hold.
REQ-024 SHALL support back-to-back pops every cycle, preserving FIFO order.

Reset
REQ-025 SHALL, on pReset=1 at a pClk edge, set the pointers to 0, count=0, empty=1, full=0, rd_valid=0, rd_data=8'h00 and overrun=0.
REQ-026 SHALL give pReset priority over uRst, wr_valid, rd_en and ovr_clr; the storage array is not reset.

Configuration
REQ-027 SHALL, with macro USRT_RX_FIFO_OVR_EN defined, implement the overrun behaviour of REQ-014, REQ-015, REQ-021 and REQ-022.
REQ-028 SHALL, without USRT_RX_FIFO_OVR_EN, tie overrun to constant 0, ignore ovr_clr, and still drop bytes arriving while full.

Structure
REQ-029 SHALL place the byte width constant (8), the default depth and the count-width helper in the shared USRT package used by the serializer, deserializer and data registers.
REQ-030 SHALL contain one natural sub-module, usrt_fifo_mem: a DEPTH x 8 register array with a synchronous write port and an addressed read mux; pointer, count and flag logic stays in the top.

Verification
REQ-031 SHALL cover: reset, then push 8'hA5 and 8'h3C, pop twice -> rd_data 8'hA5 then 8'h3C, each with rd_valid one cycle after rd_en; then count=0 and empty=1.
REQ-032 SHALL cover: DEPTH=8, push 8'h00..8'h07, then push 8'hFF -> full=1, count=8, overrun=1, 8'hFF absent; eight pops return 8'h00..8'h07.
REQ-033 SHALL cover: full FIFO, wr_valid=1 and rd_en=1 in the same cycle -> count stays 8, overrun stays 0, the new byte is popped last.
REQ-034 SHALL cover: empty FIFO, rd_en=1 with wr_valid=1 (8'h5A) -> rd_valid=0 next cycle, count=1; a following pop returns 8'h5A.
REQ-035 SHALL cover: three entries stored, uRst pulse -> count=0, empty=1, next pop ignored; overrun unchanged.
REQ-036 SHALL cover: 20 push/pop pairs with DEPTH=8 crossing pointer wrap -> data order preserved; ovr_clr together with an overflow leaves overrun=1.

Source files
------------

// File: rtl/usrt_pkg.sv
// Shared USRT constants: byte width, default receive FIFO depth and count-width helper.
// Imported by the serializer, deserializer, data registers and receive FIFO.
package usrt_pkg;

    localparam int USRT_BYTE_W     = 8;
    localparam int USRT_FIFO_DEPTH = 8;

    // A count must reach DEPTH itself, hence one bit more than the pointer.
    function automatic int usrtCountWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/usrt_fifo_mem.sv
// DEPTH x byte register array for the USRT receive FIFO.
// Synchronous write port, combinational addressed read mux.
module usrt_fifo_mem
    import usrt_pkg::*;
#(
    parameter int DEPTH = USRT_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   pClk,
    input  logic                   wrEn,
    input  logic [AW-1:0]          wrAddr,
    input  logic [USRT_BYTE_W-1:0] wrData,
    input  logic [AW-1:0]          rdAddr,
    output logic [USRT_BYTE_W-1:0] rdData
);

    logic [USRT_BYTE_W-1:0] memArray [DEPTH];

    // Storage is deliberately not reset; validity is tracked by the count.
    always_ff @(posedge pClk) begin
        if (wrEn) begin
            memArray[wrAddr] <= wrData;
        end
    end

    assign rdData = memArray[rdAddr];

endmodule

// File: rtl/usrt_rx_fifo.sv
// USRT receive FIFO between the deserializer and the AMBA-side data register.
// Build option: define USRT_RX_FIFO_OVR_EN to enable the sticky overrun flag.
module usrt_rx_fifo
    import usrt_pkg::*;
#(
    parameter int DEPTH = USRT_FIFO_DEPTH,
    parameter int CW    = usrtCountWidth(DEPTH)
) (
    input  logic                   pClk,
    input  logic                   pReset,
    input  logic                   uRst,
    input  logic                   wr_valid,
    input  logic [USRT_BYTE_W-1:0] wr_data,
    input  logic                   rd_en,
    output logic [USRT_BYTE_W-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [CW-1:0]          count,
    output logic                   overrun,
    input  logic                   ovr_clr
);

    localparam int PW = $clog2(DEPTH);

    // Handshake: a push is a one-cycle wr_valid pulse with no backpressure;
    // it is taken when not full or when a pop is taken in the same cycle,
    // otherwise the byte is dropped. A pop is rd_en while not empty, and its
    // byte appears on rd_data with a one-cycle rd_valid pulse on the next cycle.

    logic [PW-1:0]          wrPtr;
    logic [PW-1:0]          rdPtr;
    logic [CW-1:0]          cnt;
    logic [USRT_BYTE_W-1:0] memRdData;
    logic [USRT_BYTE_W-1:0] rdDataQ;
    logic                   rdValidQ;
    logic                   popAcc;
    logic                   pushAcc;
    logic                   memWrEn;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

    // A flush cycle ignores both sides of the FIFO.
    assign popAcc  = rd_en && !empty && !uRst;
    assign pushAcc = wr_valid && (!full || popAcc) && !uRst;
    assign memWrEn = pushAcc && !pReset;

    usrt_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) uMem (
        .pClk   (pClk),
        .wrEn   (memWrEn),
        .wrAddr (wrPtr),
        .wrData (wr_data),
        .rdAddr (rdPtr),
        .rdData (memRdData)
    );

    always_ff @(posedge pClk) begin
        if (pReset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            cnt      <= '0;
            rdDataQ  <= '0;
            rdValidQ <= 1'b0;
        end else if (uRst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            cnt      <= '0;
            rdValidQ <= 1'b0;
        end else begin
            rdValidQ <= popAcc;
            if (pushAcc) begin
                wrPtr <= wrPtr + 1'b1;
            end
            // When full, a simultaneous push hits rdPtr; the read mux still
            // returns the old byte because the array updates after this edge.
            if (popAcc) begin
                rdPtr   <= rdPtr + 1'b1;
                rdDataQ <= memRdData;
            end
            case ({pushAcc, popAcc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_data  = rdDataQ;
    assign rd_valid = rdValidQ;
    assign count    = cnt;

`ifdef USRT_RX_FIFO_OVR_EN
    logic dropEvt;
    logic ovrQ;

    assign dropEvt = wr_valid && full && !popAcc && !uRst;

    // Set wins over clear; a flush cycle leaves the flag alone.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            ovrQ <= 1'b0;
        end else if (!uRst) begin
            if (dropEvt) begin
                ovrQ <= 1'b1;
            end else if (ovr_clr) begin
                ovrQ <= 1'b0;
            end
        end
    end

    assign overrun = ovrQ;
`else
    assign overrun = ovr_clr & 1'b0;
`endif

endmodule
